// File: rtl/cache_req_arb.sv
// Two-port round-robin arbiter onto one cache request channel; in-order ID FIFO routes read data back.
// Request path is combinational (0-cycle), responses are registered (1 cycle); a stalled grant is locked until accepted.
module cache_req_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTSTD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [1:0]            rq_we,
  input  logic [2*ADDR_W-1:0]   rq_addr,
  input  logic [2*DATA_W-1:0]   rq_wdata,
  input  logic [2*DATA_W/8-1:0] rq_wmask,
  output logic [1:0]            rs_valid,
  output logic [DATA_W-1:0]     rs_data,
  output logic                  c_req_valid,
  input  logic                  c_req_ready,
  output logic                  c_req_we,
  output logic [ADDR_W-1:0]     c_req_addr,
  output logic [DATA_W-1:0]     c_req_wdata,
  output logic [DATA_W/8-1:0]   c_req_wmask,
  input  logic                  c_rsp_valid,
  input  logic [DATA_W-1:0]     c_rsp_data,
  output logic                  err_orphan
);

  localparam int PW = $clog2(OUTSTD);
  localparam int MW = DATA_W / 8;
  localparam logic [PW:0] FULL_CNT = OUTSTD[PW:0];

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic              ptr;
  logic              lock_port;
  logic              pick;
  logic              sel;
  logic              any_elig;
  logic [1:0]        elig;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [OUTSTD-1:0] id_mem;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop in the same cycle deliberately does not make a read eligible.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n] = rq_valid[n] & (rq_we[n] | ~full);
    end
  end

  assign any_elig = |elig;
  assign pick     = elig[ptr] ? ptr : ~ptr;
  assign sel      = (state == LOCKED) ? lock_port : pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig && !c_req_ready) state_nxt = LOCKED;
      LOCKED:  if (c_req_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    c_req_valid = 1'b0;
    rq_ready    = 2'b00;
    c_req_we    = 1'b0;
    c_req_addr  = '0;
    c_req_wdata = '0;
    c_req_wmask = '0;
    if (!rst && (state == LOCKED || any_elig)) begin
      c_req_valid   = 1'b1;
      rq_ready[sel] = c_req_ready;
      c_req_we      = rq_we[sel];
      c_req_addr    = sel ? rq_addr[ADDR_W +: ADDR_W]  : rq_addr[0 +: ADDR_W];
      c_req_wdata   = sel ? rq_wdata[DATA_W +: DATA_W] : rq_wdata[0 +: DATA_W];
      c_req_wmask   = sel ? rq_wmask[MW +: MW]         : rq_wmask[0 +: MW];
    end
  end

  assign accept = c_req_valid & c_req_ready;
  assign push   = accept & ~c_req_we;
  assign pop    = c_rsp_valid & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      lock_port <= 1'b0;
    end else begin
      if (accept) ptr <= ~sel;
      if (state == IDLE && any_elig && !c_req_ready) lock_port <= pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= sel;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_valid   <= 2'b00;
      rs_data    <= '0;
      err_orphan <= 1'b0;
    end else begin
      rs_valid <= pop ? (id_mem[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
      if (pop) rs_data <= c_rsp_data;
      if (c_rsp_valid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_req_arb.sv
// Directed bench for cache_req_arb: expected requests/responses are queued by the stimulus and checked by monitors.
module tb_cache_req_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic          p;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
  } req_t;

  typedef struct packed {
    logic          p;
    logic [DW-1:0] d;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rq_valid;
  logic [1:0]        rq_ready;
  logic [1:0]        rq_we;
  logic [2*AW-1:0]   rq_addr;
  logic [2*DW-1:0]   rq_wdata;
  logic [2*MW-1:0]   rq_wmask;
  logic [1:0]        rs_valid;
  logic [DW-1:0]     rs_data;
  logic              c_req_valid;
  logic              c_req_ready;
  logic              c_req_we;
  logic [AW-1:0]     c_req_addr;
  logic [DW-1:0]     c_req_wdata;
  logic [MW-1:0]     c_req_wmask;
  logic              c_rsp_valid;
  logic [DW-1:0]     c_rsp_data;
  logic              err_orphan;

  int   total = 0;
  int   bad   = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mon_req;
  rsp_t mon_rsp;

  cache_req_arb #(.ADDR_W(AW), .DATA_W(DW), .OUTSTD(4)) dut (
    .clk(clk), .rst(rst),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
    .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wmask(rq_wmask),
    .rs_valid(rs_valid), .rs_data(rs_data),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_req_wmask(c_req_wmask),
    .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_q(input logic p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_t r;
    r = '{p: p, we: we, addr: a, wdata: d, mask: m};
    exp_req.push_back(r);
  endtask

  task automatic exp_r(input logic p, input logic [DW-1:0] d);
    rsp_t r;
    r = '{p: p, d: d};
    exp_rsp.push_back(r);
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the request.
  task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    rq_valid[p]          = 1'b1;
    rq_we[p]             = we;
    rq_addr[p*AW +: AW]  = a;
    rq_wdata[p*DW +: DW] = d;
    rq_wmask[p*MW +: MW] = m;
    do begin
      @(negedge clk);
      n++;
    end while (!rq_ready[p] && n < 100);
    if (!rq_ready[p]) begin
      total++;
      bad++;
      $display("FAIL drive_timeout port=%0d addr=%h actual=no_ready required=ready", p, a);
    end
    @(posedge clk);
    #1;
    rq_valid[p] = 1'b0;
  endtask

  task automatic rsp(input logic [DW-1:0] d);
    c_rsp_valid = 1'b1;
    c_rsp_data  = d;
    @(posedge clk);
    #1;
    c_rsp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && c_req_valid && c_req_ready) begin
      if (exp_req.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected actual=%h required=none", c_req_addr);
      end else begin
        mon_req = exp_req.pop_front();
        chk("req_grant", rq_ready, mon_req.p ? 2'b10 : 2'b01);
        chk("req_we", c_req_we, mon_req.we);
        chk("req_addr", c_req_addr, mon_req.addr);
        chk("req_wdata", c_req_wdata, mon_req.wdata);
        chk("req_wmask", c_req_wmask, mon_req.mask);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rs_valid != 2'b00) begin
      if (exp_rsp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected actual=%b required=00", rs_valid);
      end else begin
        mon_rsp = exp_rsp.pop_front();
        chk("rsp_port", rs_valid, mon_rsp.p ? 2'b10 : 2'b01);
        chk("rsp_data", rs_data, mon_rsp.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0; rq_wmask = '0;
    c_req_ready = 1'b1; c_rsp_valid = 1'b0; c_rsp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_c_req_valid", c_req_valid, 0);
    chk("rst_rq_ready", rq_ready, 0);
    chk("rst_rs_valid", rs_valid, 0);
    chk("rst_rs_data", rs_data, 0);
    chk("rst_err_orphan", err_orphan, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read-back on port 0.
    exp_q(0, 1, 32'h1F0, 32'hDEADBEEF, 4'hF);
    drive(0, 1, 32'h1F0, 32'hDEADBEEF, 4'hF);
    exp_q(0, 0, 32'h1F0, 32'h0, 4'h0);
    drive(0, 0, 32'h1F0, 32'h0, 4'h0);
    repeat (2) @(posedge clk); #1;
    exp_r(0, 32'hDEADBEEF);
    rsp(32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    chk("t1_rs_pulse_end", rs_valid, 0);
    chk("t1_rs_data_hold", rs_data, 32'hDEADBEEF);

    // Round robin with both ports busy; reset so port 0 has priority.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_q(0, 1, 32'h100, 32'h11111111, 4'hF);
    exp_q(1, 1, 32'h200, 32'h33333333, 4'hF);
    exp_q(0, 1, 32'h104, 32'h22222222, 4'h3);
    exp_q(1, 1, 32'h204, 32'h44444444, 4'hC);
    fork
      begin
        drive(0, 1, 32'h100, 32'h11111111, 4'hF);
        drive(0, 1, 32'h104, 32'h22222222, 4'h3);
      end
      begin
        drive(1, 1, 32'h200, 32'h33333333, 4'hF);
        drive(1, 1, 32'h204, 32'h44444444, 4'hC);
      end
    join

    // Stalled grant to port 1 stays locked while port 0 (pointer port) arrives.
    c_req_ready = 1'b0;
    exp_q(1, 0, 32'h1F1, 32'h0, 4'h0);
    exp_q(0, 1, 32'h300, 32'h5A5A5A5A, 4'hF);
    fork
      drive(1, 0, 32'h1F1, 32'h0, 4'h0);
      begin
        @(posedge clk); #1;
        drive(0, 1, 32'h300, 32'h5A5A5A5A, 4'hF);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_lock_valid", c_req_valid, 1);
          chk("t3_lock_addr", c_req_addr, 32'h1F1);
          chk("t3_lock_we", c_req_we, 0);
          chk("t3_lock_ready", rq_ready, 0);
        end
        @(posedge clk); #1;
        c_req_ready = 1'b1;
      end
    join
    exp_r(1, 32'h55);
    rsp(32'h55);

    // Fill the ID FIFO; reads stall, writes pass, one pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      exp_q(0, 0, 32'h400 + 32'(4*i), 32'h0, 4'h0);
      drive(0, 0, 32'h400 + 32'(4*i), 32'h0, 4'h0);
    end
    exp_q(1, 1, 32'h500, 32'hCAFEF00D, 4'hF);
    exp_q(0, 0, 32'h410, 32'h0, 4'h0);
    fork
      drive(0, 0, 32'h410, 32'h0, 4'h0);
      begin
        @(negedge clk);
        chk("t4_full_rq_ready", rq_ready[0], 0);
        chk("t4_full_c_valid", c_req_valid, 0);
        @(posedge clk); #1;
        drive(1, 1, 32'h500, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("t4_full_after_wr", rq_ready[0], 0);
        @(posedge clk); #1;
        exp_r(0, 32'h11);
        c_rsp_valid = 1'b1;
        c_rsp_data  = 32'h11;
        @(negedge clk);
        chk("t4_pop_no_free", rq_ready[0], 0);
        @(posedge clk); #1;
        c_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t4_slot_freed", rq_ready[0], 1);
      end
    join
    for (int i = 0; i < 4; i++) begin
      exp_r(0, 32'h21 + 32'(i));
      rsp(32'h21 + 32'(i));
    end

    // Interleaved reads from both ports, responses routed in order.
    exp_q(0, 0, 32'h1F0, 32'h0, 4'h0);
    drive(0, 0, 32'h1F0, 32'h0, 4'h0);
    exp_q(1, 0, 32'h1F1, 32'h0, 4'h0);
    drive(1, 0, 32'h1F1, 32'h0, 4'h0);
    exp_r(0, 32'hA);
    exp_r(1, 32'hB);
    rsp(32'hA);
    rsp(32'hB);

    // Orphan response, then reset while LOCKED with a read outstanding.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_orphan_clear", err_orphan, 0);
    @(posedge clk); #1;
    rsp(32'h77);
    @(negedge clk);
    chk("t6_orphan_no_rs", rs_valid, 0);
    chk("t6_orphan_set", err_orphan, 1);
    @(posedge clk); #1;
    exp_q(1, 0, 32'h1F1, 32'h0, 4'h0);
    drive(1, 0, 32'h1F1, 32'h0, 4'h0);
    c_req_ready          = 1'b0;
    rq_valid[0]          = 1'b1;
    rq_we[0]             = 1'b0;
    rq_addr[0 +: AW]     = 32'h600;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_locked_valid", c_req_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_c_valid", c_req_valid, 0);
    chk("t6_rst_rq_ready", rq_ready, 0);
    chk("t6_rst_rs_valid", rs_valid, 0);
    chk("t6_rst_orphan", err_orphan, 0);
    @(posedge clk); #1;
    rq_valid    = 2'b00;
    c_req_ready = 1'b1;
    rst         = 1'b0;
    rsp(32'h88);
    @(negedge clk);
    chk("t6_fifo_emptied_rs", rs_valid, 0);
    chk("t6_fifo_emptied_orphan", err_orphan, 1);

    repeat (3) @(posedge clk);
    chk("end_req_queue", 64'(exp_req.size()), 0);
    chk("end_rsp_queue", 64'(exp_rsp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
